// File: rtl/regfile_banked.sv
// Banked register file: NRD combinational read ports, two write ports
// (wr1 outranks wr0), per-mode copies of registers BANK_LO..BANK_HI,
// one SPSR per bank, and a sequential clear sweep after reset.
// Handshake: none. Each write commits on the clock edge when its enable is
// high and the file is in RUN. Reads are combinational and bypass same-cycle
// writes by physical index. While init_busy is high, writes are dropped and
// reads return zero.
module regfile_banked #(
    parameter int DATA_W  = 32,
    parameter int NREGS   = 16,
    parameter int NRD     = 4,
    parameter int NBANK   = 4,
    parameter int BANK_LO = 13,
    parameter int BANK_HI = 14,
    localparam int ADDR_W = $clog2(NREGS),
    localparam int MODE_W = (NBANK > 1) ? $clog2(NBANK) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [MODE_W-1:0]     mode,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    input  logic                  wr0_en,
    input  logic [ADDR_W-1:0]     wr0_addr,
    input  logic [DATA_W-1:0]     wr0_data,
    input  logic                  wr0_user,
    input  logic                  wr1_en,
    input  logic [ADDR_W-1:0]     wr1_addr,
    input  logic [DATA_W-1:0]     wr1_data,
    input  logic                  spsr_wr_en,
    input  logic [DATA_W-1:0]     spsr_wr_data,
    output logic [DATA_W-1:0]     spsr,
    output logic                  init_busy
);

    localparam int NBR    = BANK_HI - BANK_LO + 1;
    localparam int NPHYS  = NREGS + (NBANK - 1) * NBR;
    localparam int PIDX_W = (NPHYS > 1) ? $clog2(NPHYS) : 1;

    typedef logic [PIDX_W-1:0] pidx_t;
    typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

    state_t              state;
    state_t              state_d;
    pidx_t               clr_idx;
    logic                wr_ok;
    logic [MODE_W-1:0]   bank_sel;
    pidx_t               p0;
    pidx_t               p1;
    pidx_t               rd_p [NRD];
    logic [DATA_W-1:0]   mem [NPHYS];
    logic [DATA_W-1:0]   spsr_q [NBANK];

    // Banked addresses in a non-user bank go to the extra entries after NREGS.
    function automatic pidx_t phys_idx(input logic [ADDR_W-1:0] a, input int b);
        int ai;
        ai = int'(a);
        if (b > 0 && ai >= BANK_LO && ai <= BANK_HI)
            return pidx_t'(NREGS + (b - 1) * NBR + (ai - BANK_LO));
        return pidx_t'(ai);
    endfunction

    // Out-of-range modes fall back to the user bank.
    always_comb begin
        bank_sel = mode;
        if (int'(mode) >= NBANK)
            bank_sel = '0;
    end

    // Physical targets of both write ports and all read ports.
    always_comb begin
        p0 = phys_idx(wr0_addr, wr0_user ? 0 : int'(bank_sel));
        p1 = phys_idx(wr1_addr, int'(bank_sel));
        for (int k = 0; k < NRD; k++)
            rd_p[k] = phys_idx(rd_addr[k*ADDR_W +: ADDR_W], int'(bank_sel));
    end

    // State register and clear index; reset restarts the sweep from entry 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_idx <= '0;
        end else begin
            state <= state_d;
            if (state == CLEAR)
                clr_idx <= clr_idx + pidx_t'(1);
        end
    end

    // Next state: leave CLEAR once the last physical entry has been zeroed.
    always_comb begin
        state_d = state;
        case (state)
            CLEAR:   if (clr_idx == pidx_t'(NPHYS - 1)) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = CLEAR;
        endcase
    end

    // FSM outputs: busy flag and the write/bypass qualifier.
    always_comb begin
        init_busy = (state == CLEAR);
        wr_ok     = (state == RUN) && !rst;
    end

    // Storage has no reset so it can map to RAM; the sweep clears it instead.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[clr_idx] <= '0;
            end else begin
                if (wr0_en) mem[p0] <= wr0_data;
                if (wr1_en) mem[p1] <= wr1_data;  // later assignment wins on a tie
            end
        end
    end

    // SPSRs are few, so they are reset directly rather than swept.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < NBANK; b++)
                spsr_q[b] <= '0;
        end else if (wr_ok && spsr_wr_en) begin
            spsr_q[bank_sel] <= spsr_wr_data;
        end
    end

    // Read ports with same-cycle bypass; wr1 is checked first.
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NRD; k++) begin
            if (init_busy)
                rd_data[k*DATA_W +: DATA_W] = '0;
            else if (wr_ok && wr1_en && rd_p[k] == p1)
                rd_data[k*DATA_W +: DATA_W] = wr1_data;
            else if (wr_ok && wr0_en && rd_p[k] == p0)
                rd_data[k*DATA_W +: DATA_W] = wr0_data;
            else
                rd_data[k*DATA_W +: DATA_W] = mem[rd_p[k]];
        end
    end

    // SPSR of the current mode, with bypass of a same-cycle write.
    always_comb begin
        spsr = spsr_q[bank_sel];
        if (init_busy)
            spsr = '0;
        else if (wr_ok && spsr_wr_en)
            spsr = spsr_wr_data;
    end

endmodule

// File: tb/tb_regfile_banked.sv
// Bench for regfile_banked: directed scenarios with literal expectations,
// randomized traffic, and a per-cycle compare against a banked-array model.
module tb_regfile_banked;

    localparam int DW    = 32;
    localparam int NR    = 16;
    localparam int NRD   = 4;
    localparam int NB    = 4;
    localparam int AW    = 4;
    localparam int MW    = 2;
    localparam int NPHYS = 22;

    logic              clk = 1'b0;
    logic              rst;
    logic [MW-1:0]     mode;
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD*DW-1:0] rd_data;
    logic              wr0_en;
    logic [AW-1:0]     wr0_addr;
    logic [DW-1:0]     wr0_data;
    logic              wr0_user;
    logic              wr1_en;
    logic [AW-1:0]     wr1_addr;
    logic [DW-1:0]     wr1_data;
    logic              spsr_wr_en;
    logic [DW-1:0]     spsr_wr_data;
    logic [DW-1:0]     spsr;
    logic              init_busy;

    int checks = 0;
    int errors = 0;

    regfile_banked dut (
        .clk(clk), .rst(rst), .mode(mode), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_user(wr0_user),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .spsr_wr_en(spsr_wr_en), .spsr_wr_data(spsr_wr_data), .spsr(spsr),
        .init_busy(init_busy)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- model ----------------
    // Shared registers plus a separate copy of r13/r14 for each non-user mode.
    logic [DW-1:0] ureg [NR];
    logic [DW-1:0] breg [NB][2];
    logic [DW-1:0] m_spsr [NB];
    int            busy_left = 0;
    bit            started = 0;

    function automatic int key(input int a, input int b);
        if (b > 0 && a >= 13 && a <= 14) return 100 * b + a;
        return a;
    endfunction

    function automatic logic [DW-1:0] m_get(input int a, input int b);
        if (b > 0 && a >= 13 && a <= 14) return breg[b][a-13];
        return ureg[a];
    endfunction

    task automatic m_set(input int a, input int b, input logic [DW-1:0] d);
        if (b > 0 && a >= 13 && a <= 14) breg[b][a-13] = d;
        else ureg[a] = d;
    endtask

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] port(input int k);
        return rd_data[k*DW +: DW];
    endfunction

    // ---------------- scoreboard / compare ----------------
    always begin : compare
        int b, a;
        logic [DW-1:0] e;
        @(negedge clk);
        #2;
        b = int'(mode);
        if (started && !rst) begin
            chk("init_busy", 32'(init_busy), 32'(busy_left > 0));
            for (int k = 0; k < NRD; k++) begin
                a = int'(rd_addr[k*AW +: AW]);
                if (busy_left > 0) e = '0;
                else if (wr1_en && key(a, b) == key(int'(wr1_addr), b)) e = wr1_data;
                else if (wr0_en && key(a, b) == key(int'(wr0_addr), wr0_user ? 0 : b)) e = wr0_data;
                else e = m_get(a, b);
                chk($sformatf("rd%0d a=%0d m=%0d", k, a, b), port(k), e);
            end
            if (busy_left > 0) e = '0;
            else if (spsr_wr_en) e = spsr_wr_data;
            else e = m_spsr[b];
            chk($sformatf("spsr m=%0d", b), spsr, e);
        end
        // advance the model across the coming rising edge
        if (rst) begin
            started = 1;
            busy_left = NPHYS;
            for (int i = 0; i < NR; i++) ureg[i] = '0;
            for (int i = 0; i < NB; i++) begin
                breg[i][0] = '0; breg[i][1] = '0; m_spsr[i] = '0;
            end
        end else if (started) begin
            if (busy_left > 0) busy_left--;
            else begin
                if (wr0_en) m_set(int'(wr0_addr), wr0_user ? 0 : b, wr0_data);
                if (wr1_en) m_set(int'(wr1_addr), b, wr1_data);
                if (spsr_wr_en) m_spsr[b] = spsr_wr_data;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle();
        wr0_en = 0; wr1_en = 0; wr0_user = 0; spsr_wr_en = 0;
    endtask

    task automatic rd_all(input int a);
        for (int k = 0; k < NRD; k++) rd_addr[k*AW +: AW] = AW'(a);
    endtask

    task automatic rnd_inputs();
        int r;
        mode         = MW'($urandom_range(0, 3));
        wr0_en       = ($urandom_range(0, 2) != 0);
        wr0_addr     = AW'($urandom_range(0, 15));
        wr0_data     = $urandom;
        wr0_user     = ($urandom_range(0, 3) == 0);
        wr1_en       = ($urandom_range(0, 2) != 0);
        wr1_addr     = ($urandom_range(0, 3) == 0) ? wr0_addr : AW'($urandom_range(0, 15));
        wr1_data     = $urandom;
        spsr_wr_en   = ($urandom_range(0, 3) == 0);
        spsr_wr_data = $urandom;
        for (int k = 0; k < NRD; k++) begin
            r = $urandom_range(0, 3);
            case (r)
                0: rd_addr[k*AW +: AW] = wr0_addr;
                1: rd_addr[k*AW +: AW] = wr1_addr;
                2: rd_addr[k*AW +: AW] = AW'($urandom_range(12, 15));
                default: rd_addr[k*AW +: AW] = AW'($urandom_range(0, 15));
            endcase
        end
    endtask

    // Called at the negedge right after rst drops; counts busy cycles while
    // throwing random writes at the busy file. Optional early reset at idx.
    task automatic sweep(input int rst_at, output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (i < NPHYS - 2) rnd_inputs(); else idle();
            if (i == rst_at) rst = 1;
            #3;
            if (!init_busy) break;
            n++;
            @(negedge clk);
            if (rst) begin
                rst = 0;
                n = 0;
                i = -1;
                rst_at = -1;
            end
        end
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        int n;
        rst = 1; mode = 0; rd_addr = '0; idle();
        wr0_addr = 0; wr0_data = 0; wr1_addr = 0; wr1_data = 0; spsr_wr_data = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        sweep(-1, n);
        chk("busy_cycles", 32'(n), 32'(NPHYS));

        // all registers read 0 in every mode after the sweep
        for (int m = 0; m < NB; m++)
            for (int base = 0; base < NR; base += NRD) begin
                @(negedge clk); idle(); mode = MW'(m);
                for (int k = 0; k < NRD; k++) rd_addr[k*AW +: AW] = AW'(base + k);
                #3;
                for (int k = 0; k < NRD; k++) chk("post_reset_zero", port(k), 32'h0);
            end

        // banked r13/r14
        @(negedge clk); idle(); mode = 0;
        wr0_en = 1; wr0_addr = 13; wr0_data = 32'hAAAA0000;
        @(negedge clk); idle(); mode = 2;
        wr0_en = 1; wr0_addr = 13; wr0_data = 32'hBBBB0000;
        wr1_en = 1; wr1_addr = 14; wr1_data = 32'h1234;
        @(negedge clk); idle(); mode = 0; rd_all(13); #3;
        chk("m0_r13", port(0), 32'hAAAA0000);
        @(negedge clk); mode = 2; rd_all(13); rd_addr[AW +: AW] = 14; #3;
        chk("m2_r13", port(0), 32'hBBBB0000);
        chk("m2_r14", port(1), 32'h1234);
        @(negedge clk); mode = 1; rd_all(13); #3;
        chk("m1_r13", port(2), 32'h0);
        @(negedge clk); mode = 3; wr0_en = 1; wr0_addr = 5; wr0_data = 32'h77;
        @(negedge clk); idle(); mode = 0; rd_all(5); #3;
        chk("r5_m0", port(3), 32'h77);
        @(negedge clk); mode = 1; #3;
        chk("r5_m1", port(0), 32'h77);

        // same-cycle collision: wr1 wins, bypass on every port
        @(negedge clk); mode = 0; rd_all(3);
        wr0_en = 1; wr0_addr = 3; wr0_data = 32'h11;
        wr1_en = 1; wr1_addr = 3; wr1_data = 32'h22; #3;
        for (int k = 0; k < NRD; k++) chk("collide_bypass", port(k), 32'h22);
        @(negedge clk); idle(); #3;
        chk("collide_store", port(1), 32'h22);
        @(negedge clk);
        wr0_en = 1; wr0_addr = 3; wr0_data = 32'h33;
        wr1_en = 1; wr1_addr = 4; wr1_data = 32'h44;
        @(negedge clk); idle(); rd_addr[0 +: AW] = 3; rd_addr[AW +: AW] = 4; #3;
        chk("dual_r3", port(0), 32'h33);
        chk("dual_r4", port(1), 32'h44);

        // user-bank store from mode 1 does not bypass a mode-1 read
        @(negedge clk); mode = 1; wr1_en = 1; wr1_addr = 13; wr1_data = 32'h99;
        @(negedge clk); idle(); rd_all(13);
        wr0_en = 1; wr0_user = 1; wr0_addr = 13; wr0_data = 32'h55; #3;
        chk("user_no_bypass", port(0), 32'h99);
        @(negedge clk); idle(); mode = 0; #3;
        chk("user_store_m0", port(0), 32'h55);

        // SPSR per mode
        @(negedge clk); mode = 1; spsr_wr_en = 1; spsr_wr_data = 32'hF00D; #3;
        chk("spsr_bypass", spsr, 32'hF00D);
        @(negedge clk); mode = 3; spsr_wr_data = 32'hBEEF;
        @(negedge clk); idle(); mode = 1; #3;
        chk("spsr_m1", spsr, 32'hF00D);
        @(negedge clk); mode = 3; #3;
        chk("spsr_m3", spsr, 32'hBEEF);
        @(negedge clk); mode = 0; #3;
        chk("spsr_m0", spsr, 32'h0);

        // random traffic, checked every cycle by the compare process
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            rnd_inputs();
        end

        // reset, then reset again mid-sweep at index 7
        @(negedge clk); idle(); rst = 1;
        @(negedge clk); rst = 0;
        sweep(7, n);
        chk("restart_busy_cycles", 32'(n), 32'(NPHYS));
        for (int m = 0; m < NB; m++)
            for (int base = 0; base < NR; base += NRD) begin
                @(negedge clk); idle(); mode = MW'(m);
                for (int k = 0; k < NRD; k++) rd_addr[k*AW +: AW] = AW'(base + k);
                #3;
                for (int k = 0; k < NRD; k++) chk("restart_zero", port(k), 32'h0);
                chk("restart_spsr", spsr, 32'h0);
            end

        @(negedge clk); idle();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
